// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and counter sizing for uart_tx (UARTTX_PARITY_EN adds PARITY)
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UARTTX_PARITY_EN
    PARITY,
`endif
    STOP,
    CLEANUP
  } state_e;
  function automatic int cnt_width(input int cpb);
    return (cpb > 2) ? $clog2(cpb) : 1;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter emitting a tick on the last cycle of each bit, clearable by the FSM
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == LAST;
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first; define UARTTX_PARITY_EN to insert an even parity bit before stop
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);
  state_e     state_q;
  logic [7:0] data_q;
  logic [2:0] bit_q;
  logic       tick;
`ifdef UARTTX_PARITY_EN
  logic       par_q;
`endif
  // counter is held at zero outside a frame so START always lasts a full period
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .clr_i (state_q == IDLE || state_q == CLEANUP),
    .tick_o(tick)
  );
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      bit_q       <= '0;
      o_TX_Serial <= LINE_IDLE;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
`ifdef UARTTX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      o_TX_Done <= 1'b0;
      case (state_q)
        IDLE: if (i_TX_DV) begin
          state_q     <= START;
          data_q      <= i_TX_Byte;
          bit_q       <= '0;
          o_TX_Serial <= 1'b0;
          o_TX_Active <= 1'b1;
`ifdef UARTTX_PARITY_EN
          par_q       <= ^i_TX_Byte;
`endif
        end
        START: if (tick) begin
          state_q     <= DATA;
          o_TX_Serial <= data_q[0];
        end
        DATA: if (tick) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UARTTX_PARITY_EN
            state_q     <= PARITY;
            o_TX_Serial <= par_q;
`else
            state_q     <= STOP;
            o_TX_Serial <= LINE_IDLE;
`endif
          end else begin
            bit_q       <= bit_q + 3'd1;
            data_q      <= {1'b0, data_q[7:1]};
            o_TX_Serial <= data_q[1];
          end
        end
`ifdef UARTTX_PARITY_EN
        PARITY: if (tick) begin
          state_q     <= STOP;
          o_TX_Serial <= LINE_IDLE;
        end
`endif
        STOP: if (tick) begin
          state_q     <= CLEANUP;
          o_TX_Active <= 1'b0;
          o_TX_Done   <= 1'b1;
          o_TX_Serial <= LINE_IDLE;
        end
        CLEANUP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx; a line monitor decodes frames and checks them against queued bytes
module tb_uart_tx;
  localparam int CPB = 217;
`ifdef UARTTX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int SPACING = FRAME * CPB + 2;

  logic       clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       o_active, o_serial, o_done;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (dv),
    .i_TX_Byte  (byte_in),
    .o_TX_Active(o_active),
    .o_TX_Serial(o_serial),
    .o_TX_Done  (o_done)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(posedge clk) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  int last_acc = -100000, last_start = -1, prev_start = -1, frames_ok = 0, n_sent = 0;
  bit aborted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // the transmitter is free again once SPACING cycles have passed since the last acceptance
  task automatic send(input logic [7:0] b);
    dv = 1'b1;
    byte_in = b;
    if (cyc + 1 - last_acc >= SPACING) begin
      exp_q.push_back(b);
      last_acc = cyc + 1;
      n_sent++;
    end
    tick;
    dv = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic wait_idle;
    while (cyc + 1 - last_acc < SPACING) tick;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // monitor: decode any frame seen on the line, independent of the stimulus
  logic [FRAME-1:0] bits;
  logic [7:0] got, e;
  logic act_ok, d1, d2, a1;
  int a;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && o_serial === 1'b0) begin
        a = cyc;
        prev_start = last_start;
        last_start = a;
        act_ok = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
          wait_cyc(a + k * CPB + CPB / 2);
          bits[k] = o_serial;
          act_ok &= o_active;
        end
        wait_cyc(a + FRAME * CPB);
        d1 = o_done;
        a1 = o_active;
        wait_cyc(a + FRAME * CPB + 1);
        d2 = o_done;
        for (int i = 0; i < 8; i++) got[i] = bits[i + 1];
        if (aborted) begin
          aborted = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", got, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("start_bit", bits[0], 0);
          check("data_byte", got, e);
`ifdef UARTTX_PARITY_EN
          check("parity_bit", bits[9], ^e);
`endif
          check("stop_bit", bits[FRAME-1], 1);
          check("active_in_frame", act_ok, 1);
          check("done_at_frame_end", d1, 1);
          check("active_at_frame_end", a1, 0);
          check("done_one_cycle", d2, 0);
          frames_ok++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int dc, s;
  initial begin
    repeat (3) tick;
    check("reset_serial", o_serial, 1);
    check("reset_active", o_active, 0);
    check("reset_done", o_done, 0);
    rst = 1'b0;
    tick;
    send(8'hAA);
    wait_idle;
    send(8'h3F);
    wait_idle;
    // a strobe during DATA must be dropped
    send(8'h55);
    s = last_acc;
    while (cyc < s + 3 * CPB) tick;
    send(8'hFF);
    wait_idle;
    // reset during data bit 3 aborts the frame without a Done pulse
    send(8'hC3);
    s = last_acc;
    while (cyc < s + 4 * CPB + CPB / 2) tick;
    aborted = 1'b1;
    rst = 1'b1;
    tick;
    check("midreset_serial", o_serial, 1);
    check("midreset_active", o_active, 0);
    check("midreset_done", o_done, 0);
    rst = 1'b0;
    n_sent--;
    dc = done_cnt;
    repeat (7 * CPB) tick;
    check("no_done_after_reset", done_cnt, dc);
    last_acc = -100000;
    send(8'h81);
    wait_idle;
    // DV held high: second frame starts on the first IDLE edge after CLEANUP
    dv = 1'b1;
    byte_in = 8'hA5;
    exp_q.push_back(8'hA5);
    last_acc = cyc + 1;
    n_sent++;
    tick;
    byte_in = 8'h5A;
    while (cyc + 1 - last_acc < SPACING) tick;
    exp_q.push_back(8'h5A);
    last_acc = cyc + 1;
    n_sent++;
    tick;
    dv = 1'b0;
    wait_idle;
    repeat (2) tick;
    check("back_to_back_gap", last_start - prev_start, SPACING);
    for (int n = 0; n < 6; n++) begin
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, FRAME * CPB)) tick;
        send(8'($urandom));
      end
      wait_idle;
      repeat ($urandom_range(0, 5)) tick;
    end
    repeat (4) tick;
    check("queue_drained", exp_q.size(), 0);
    check("done_total", done_cnt, n_sent);
    check("frames_decoded", frames_ok, n_sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
